uart_mmio_fifo: RTL

Parametrised next-generation memory-mapped UART for the CPU peripheral bus. It adds TX and RX FIFOs, a runtime-programmable baud divisor, sticky error flags with write-1-to-clear, FIFO fill counters and a maskable interrupt. Its own TX/RX shift engines run 8N1 framing, LSB first, and sit directly between the CPU MMIO decode and the uart_tx/uart_rx pins.

---
 rtl/uart_mmio_fifo.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, runtime divisor, W1C sticky flags and irq.
// Define UART_LOOPBACK_EN to make CTRL[4] an internal TX->RX loopback.
`timescale 1ns/1ps
module uart_mmio_fifo #(
  parameter int unsigned CLK_FRE    = 27,
  parameter int unsigned UART_FRE   = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic [2:0] addr,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       irq
);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned DIV_RST  = CLK_FRE * 1000000 / UART_FRE;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
`ifdef UART_LOOPBACK_EN
  localparam logic [4:0]  CTRL_WMASK = 5'h1F;
`else
  localparam logic [4:0]  CTRL_WMASK = 5'h0F;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [4:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d, div_eff;
  logic [2:0]  sticky_q, sticky_d, sticky_set, sticky_clr;
  logic        irq_q, irq_d;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp_q, tx_rp_q, tx_count;
  logic        tx_empty, tx_full, tx_push, tx_pop, tx_ovf_set, wr_tx;
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wp_q, rx_rp_q, rx_count;
  logic        rx_empty, rx_full, rx_push, rx_pop, rx_ovr_set;

  state_e      tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_line_q, tx_line_d, tx_start, tx_idle;

  state_e      rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_in, rx_push_req, rx_ferr_set;
  logic [7:0]  stat;

`ifdef UART_LOOPBACK_EN
  assign rx_in   = ctrl_q[4] ? tx_line_q : uart_rx;
  assign uart_tx = ctrl_q[4] ? 1'b1 : tx_line_q;
`else
  assign rx_in   = uart_rx;
  assign uart_tx = tx_line_q;
`endif

  assign div_eff    = (div_q < 16'd4) ? 16'd4 : div_q;
  assign tx_count   = tx_wp_q - tx_rp_q;
  assign rx_count   = rx_wp_q - rx_rp_q;
  assign tx_empty   = (tx_count == '0);
  assign rx_empty   = (rx_count == '0);
  assign tx_full    = (tx_count == FULL_CNT);
  assign rx_full    = (rx_count == FULL_CNT);
  assign tx_idle    = tx_empty && (tx_st_q == S_IDLE);

  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign wr_tx      = wr_en && (addr == 3'd2);
  assign tx_push    = wr_tx && (!tx_full || tx_pop);
  assign tx_ovf_set = wr_tx && tx_full && !tx_pop;
  assign rx_pop     = rd_en && (addr == 3'd3) && !rx_empty;
  assign rx_push    = rx_push_req && (!rx_full || rx_pop);
  assign rx_ovr_set = rx_push_req && rx_full && !rx_pop;

  assign stat = {tx_empty, rx_full, sticky_q, tx_idle, !tx_full, !rx_empty};
  assign irq  = irq_q;

  always_comb begin
    ctrl_d     = ctrl_q;
    div_d      = div_q;
    sticky_clr = '0;
    if (wr_en) begin
      case (addr)
        3'd0:    ctrl_d = wr_data[4:0] & CTRL_WMASK;
        3'd1:    sticky_clr = wr_data[5:3];
        3'd4:    div_d[7:0] = wr_data;
        3'd5:    div_d[15:8] = wr_data;
        default: ;
      endcase
    end
    sticky_set = {tx_ovf_set, rx_ferr_set, rx_ovr_set};
    sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;
    irq_d      = (ctrl_q[2] && !rx_empty) || (ctrl_q[3] && tx_empty);
  end

  always_comb begin
    case (addr)
      3'd0:    rd_data = {3'b000, ctrl_q};
      3'd1:    rd_data = stat;
      3'd3:    rd_data = rx_empty ? '0 : rx_mem[rx_rp_q[AW-1:0]];
      3'd4:    rd_data = div_q[7:0];
      3'd5:    rd_data = div_q[15:8];
      3'd6:    rd_data = 8'(rx_count);
      3'd7:    rd_data = 8'(tx_count);
      default: rd_data = '0;
    endcase
  end

  // TX engine; the divisor is latched at each START so mid-frame writes wait a frame.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_div_d = tx_div_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_pop   = 1'b0;
    tx_start = ctrl_q[0] && !tx_empty;
    unique case (tx_st_q)
      S_IDLE: begin
        if (tx_start) begin
          tx_st_d  = S_START;
          tx_pop   = 1'b1;
          tx_sh_d  = tx_mem[tx_rp_q[AW-1:0]];
          tx_div_d = div_eff;
          tx_cnt_d = div_eff - 16'd1;
        end
      end
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_st_d  = S_DATA;
          tx_cnt_d = tx_div_q - 16'd1;
          tx_bit_d = '0;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_cnt_d = tx_div_q - 16'd1;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (tx_cnt_q == '0) begin
          if (tx_start) begin
            tx_st_d  = S_START;
            tx_pop   = 1'b1;
            tx_sh_d  = tx_mem[tx_rp_q[AW-1:0]];
            tx_div_d = div_eff;
            tx_cnt_d = div_eff - 16'd1;
          end else tx_st_d = S_IDLE;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_st_d = S_IDLE;
    endcase
    tx_line_d = (tx_st_q == S_START) ? 1'b0 :
                (tx_st_q == S_DATA)  ? tx_sh_q[0] : 1'b1;
  end

  // RX engine: start is confirmed at half a bit, then each bit sampled one DIV later.
  always_comb begin
    rx_st_d     = rx_st_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_push_req = 1'b0;
    rx_ferr_set = 1'b0;
    unique case (rx_st_q)
      S_IDLE: begin
        if (ctrl_q[1] && rx_s3_q && !rx_s2_q) begin
          rx_st_d  = S_START;
          rx_div_d = div_eff;
          rx_cnt_d = {1'b0, div_eff[15:1]} - 16'd1;
        end
      end
      S_START: begin
        if (rx_cnt_q == '0) begin
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
          rx_cnt_d = rx_div_q - 16'd1;
          rx_bit_d = '0;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_d = rx_div_q - 16'd1;
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_st_d     = S_IDLE;
          rx_push_req = rx_s2_q;
          rx_ferr_set = !rx_s2_q;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= wr_data;
    if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= 5'h03;
      div_q     <= DIV_RST[15:0];
      sticky_q  <= '0;
      irq_q     <= 1'b0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= '0;
      tx_div_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_line_q <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_div_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_s3_q   <= 1'b1;
    end else begin
      ctrl_q    <= ctrl_d;
      div_q     <= div_d;
      sticky_q  <= sticky_d;
      irq_q     <= irq_d;
      if (tx_push) tx_wp_q <= tx_wp_q + PTR_ONE;
      if (tx_pop)  tx_rp_q <= tx_rp_q + PTR_ONE;
      if (rx_push) rx_wp_q <= rx_wp_q + PTR_ONE;
      if (rx_pop)  rx_rp_q <= rx_rp_q + PTR_ONE;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_div_q  <= tx_div_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_line_q <= tx_line_d;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_div_q  <= rx_div_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_s1_q   <= rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_s3_q   <= rx_s2_q;
    end
  end
endmodule
